// File: rtl/egress_pkt_arbiter_pkg.sv
// egress_pkt_arbiter_pkg: shared egress queue entry widths, layout helper and arbiter state encodings
package egress_pkt_arbiter_pkg;
  localparam int EQ_DATA_WIDTH = 256;
  localparam int EQ_KEEP_WIDTH = 8;
  localparam int EQ_USER_WIDTH = 22;
  localparam int EQ_CNT_WIDTH  = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;
  function automatic int eq_width(input int dw, input int kw, input int uw);
    return dw + kw + uw + 2;
  endfunction
endpackage

// File: rtl/egress_entry_unpack.sv
// egress_entry_unpack: split a queue entry into data/keep/user/start/end fields
module egress_entry_unpack
  import egress_pkt_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = EQ_DATA_WIDTH,
  parameter int KEEP_WIDTH = EQ_KEEP_WIDTH,
  parameter int USER_WIDTH = EQ_USER_WIDTH,
  localparam int EW = eq_width(DATA_WIDTH, KEEP_WIDTH, USER_WIDTH)
) (
  input  logic [EW-1:0]         iv_entry,
  output logic [DATA_WIDTH-1:0] ov_data,
  output logic [KEEP_WIDTH-1:0] ov_keep,
  output logic [USER_WIDTH-1:0] ov_user,
  output logic                  o_start,
  output logic                  o_end
);
  assign ov_data = iv_entry[DATA_WIDTH-1:0];
  assign ov_keep = iv_entry[DATA_WIDTH +: KEEP_WIDTH];
  assign ov_user = iv_entry[DATA_WIDTH+KEEP_WIDTH +: USER_WIDTH];
  assign o_start = iv_entry[EW-2];
  assign o_end   = iv_entry[EW-1];
endmodule

// File: rtl/egress_pkt_arbiter.sv
// egress_pkt_arbiter: packet-granular round-robin merge of two FWFT egress queues onto one tx stream
module egress_pkt_arbiter
  import egress_pkt_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH         = EQ_DATA_WIDTH,
  parameter int KEEP_WIDTH         = EQ_KEEP_WIDTH,
  parameter int USER_WIDTH         = EQ_USER_WIDTH,
  parameter int EGRESS_QUEUE_WIDTH = eq_width(DATA_WIDTH, KEEP_WIDTH, USER_WIDTH),
  parameter int CNT_WIDTH          = EQ_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_q0_empty,
  input  logic [EGRESS_QUEUE_WIDTH-1:0] iv_q0_dout,
  output logic                          o_q0_rd_en,
  input  logic                          i_q1_empty,
  input  logic [EGRESS_QUEUE_WIDTH-1:0] iv_q1_dout,
  output logic                          o_q1_rd_en,
  output logic                          o_tx_pkt_valid,
  output logic                          o_tx_pkt_start,
  output logic                          o_tx_pkt_end,
  output logic [USER_WIDTH-1:0]         ov_tx_pkt_user,
  output logic [KEEP_WIDTH-1:0]         ov_tx_pkt_keep,
  output logic [DATA_WIDTH-1:0]         ov_tx_pkt_data,
  input  logic                          i_tx_pkt_ready,
  output logic [CNT_WIDTH-1:0]          ov_q0_pkt_cnt,
  output logic [CNT_WIDTH-1:0]          ov_q1_pkt_cnt,
  output logic [CNT_WIDTH-1:0]          ov_frame_err_cnt
);
  logic [EGRESS_QUEUE_WIDTH-1:0] w_dout [2];
  logic [DATA_WIDTH-1:0]         w_data [2];
  logic [KEEP_WIDTH-1:0]         w_keep [2];
  logic [USER_WIDTH-1:0]         w_user [2];
  logic [1:0]                    w_st, w_en;
  state_t r_state;
  logic   r_rr, r_src;
  logic   w_free, w_idle, w_sel0, w_sel1, w_pop, w_start, w_end, w_fwd, w_err;
  assign w_dout[0] = iv_q0_dout;
  assign w_dout[1] = iv_q1_dout;
  for (genvar g = 0; g < 2; g++) begin : g_unpack
    egress_entry_unpack #(
      .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH), .USER_WIDTH(USER_WIDTH)
    ) u_unpack (
      .iv_entry(w_dout[g]), .ov_data(w_data[g]), .ov_keep(w_keep[g]),
      .ov_user(w_user[g]), .o_start(w_st[g]), .o_end(w_en[g])
    );
  end
  assign w_free = !o_tx_pkt_valid | i_tx_pkt_ready;
  assign w_idle = r_state == IDLE;
  // r_rr names the queue preferred when both have a packet waiting
  assign w_sel1 = (r_state == LOCK1) | (w_idle & !i_q1_empty & (i_q0_empty | r_rr));
  assign w_sel0 = (r_state == LOCK0) | (w_idle & !w_sel1);
  assign o_q0_rd_en = w_free & !i_q0_empty & w_sel0;
  assign o_q1_rd_en = w_free & !i_q1_empty & w_sel1;
  assign w_pop   = o_q0_rd_en | o_q1_rd_en;
  assign w_start = w_sel1 ? w_st[1] : w_st[0];
  assign w_end   = w_sel1 ? w_en[1] : w_en[0];
  assign w_fwd   = w_pop & (w_start | !w_idle);
  assign w_err   = w_pop & (w_start ^ w_idle);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tx_pkt_valid   <= 1'b0;
      o_tx_pkt_start   <= 1'b0;
      o_tx_pkt_end     <= 1'b0;
      ov_tx_pkt_user   <= '0;
      ov_tx_pkt_keep   <= '0;
      ov_tx_pkt_data   <= '0;
      ov_q0_pkt_cnt    <= '0;
      ov_q1_pkt_cnt    <= '0;
      ov_frame_err_cnt <= '0;
      r_state          <= IDLE;
      r_rr             <= 1'b0;
      r_src            <= 1'b0;
    end else begin
      if (w_free) begin
        o_tx_pkt_valid <= w_fwd;
        if (w_fwd) begin
          o_tx_pkt_start <= w_start;
          o_tx_pkt_end   <= w_end;
          ov_tx_pkt_user <= w_sel1 ? w_user[1] : w_user[0];
          ov_tx_pkt_keep <= w_sel1 ? w_keep[1] : w_keep[0];
          ov_tx_pkt_data <= w_sel1 ? w_data[1] : w_data[0];
          r_src          <= w_sel1;
        end
      end
      if (w_pop && w_start) begin
        r_rr    <= !w_sel1;
        r_state <= w_end ? IDLE : (w_sel1 ? LOCK1 : LOCK0);
      end else if (w_pop && !w_idle && w_end)
        r_state <= IDLE;
      if (w_err && !(&ov_frame_err_cnt))
        ov_frame_err_cnt <= ov_frame_err_cnt + 1'b1;
      if (o_tx_pkt_valid && i_tx_pkt_ready && o_tx_pkt_end) begin
        if (r_src) ov_q1_pkt_cnt <= ov_q1_pkt_cnt + 1'b1;
        else       ov_q0_pkt_cnt <= ov_q0_pkt_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_egress_pkt_arbiter.sv
// tb_egress_pkt_arbiter: directed self-checking bench with behavioural FWFT queues and a tx beat monitor
module tb_egress_pkt_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready = 1'b1;
  logic q0_empty, q1_empty, q0_rd, q1_rd;
  logic [287:0] q0_dout, q1_dout, beat;
  logic valid, start, pend;
  logic [21:0] user;
  logic [7:0] keep;
  logic [255:0] data;
  logic [31:0] cnt0, cnt1, errc;
  logic [287:0] m0 [256];
  logic [287:0] m1 [256];
  logic [7:0] h0 = '0, t0 = '0, h1 = '0, t1 = '0;
  logic [287:0] cap [$];
  logic [287:0] exp_q [$];
  int checks = 0, errors = 0, dual_err = 0;

  always #5 clk = ~clk;

  egress_pkt_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_q0_empty(q0_empty), .iv_q0_dout(q0_dout), .o_q0_rd_en(q0_rd),
    .i_q1_empty(q1_empty), .iv_q1_dout(q1_dout), .o_q1_rd_en(q1_rd),
    .o_tx_pkt_valid(valid), .o_tx_pkt_start(start), .o_tx_pkt_end(pend),
    .ov_tx_pkt_user(user), .ov_tx_pkt_keep(keep), .ov_tx_pkt_data(data),
    .i_tx_pkt_ready(ready),
    .ov_q0_pkt_cnt(cnt0), .ov_q1_pkt_cnt(cnt1), .ov_frame_err_cnt(errc)
  );

  assign q0_empty = h0 == t0;
  assign q1_empty = h1 == t1;
  assign q0_dout  = m0[h0];
  assign q1_dout  = m1[h1];
  assign beat     = {pend, start, user, keep, data};

  always @(posedge clk) begin
    if (q0_rd) h0 <= h0 + 8'd1;
    if (q1_rd) h1 <= h1 + 8'd1;
  end

  always @(negedge clk) begin
    if (valid && ready) cap.push_back(beat);
    if (q0_rd && q1_rd) begin
      dual_err++;
      $display("FAIL dual_rd_en got q0=%b q1=%b want at most one", q0_rd, q1_rd);
    end
  end

  function automatic logic [287:0] mk(input int q, input int p, input int b, input logic s, input logic e);
    return {e, s, 22'(q * 256 + p), 8'(32'hF0 ^ b), 256'(q * 65536 + p * 256 + b)};
  endfunction

  task automatic push0(input logic [287:0] e);
    m0[t0] = e;
    t0 = t0 + 8'd1;
  endtask

  task automatic push1(input logic [287:0] e);
    m1[t1] = e;
    t1 = t1 + 8'd1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    t0 = h0;
    t1 = h1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (beat !== '0) begin errors++; $display("FAIL reset_beat got %h want 0", beat); end
    checks++; if ({cnt0, cnt1, errc} !== '0) begin errors++; $display("FAIL reset_cnts got %h/%h/%h want 0", cnt0, cnt1, errc); end
    checks++; if ({q0_rd, q1_rd} !== 2'b00) begin errors++; $display("FAIL reset_rd_en got %b want 00", {q0_rd, q1_rd}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_pkt;
    apply_reset;
    push0(mk(0, 1, 0, 1, 0));
    push0(mk(0, 1, 1, 0, 0));
    push0(mk(0, 1, 2, 0, 1));
    @(negedge clk);
    checks++; if (valid !== 1'b0 || q0_rd !== 1'b1) begin errors++; $display("FAIL single_latency got valid=%b rd=%b want 0/1", valid, q0_rd); end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b1 || beat !== mk(0, 1, b, b == 0, b == 2)) begin
        errors++; $display("FAIL single_beat%0d got v=%b %h want v=1 %h", b, valid, beat, mk(0, 1, b, b == 0, b == 2));
      end
    end
    @(negedge clk);
    checks++; if (cnt0 !== 32'd1 || valid !== 1'b0) begin errors++; $display("FAIL single_cnt got cnt0=%0d valid=%b want 1/0", cnt0, valid); end
  endtask

  task automatic test_round_robin;
    apply_reset;
    for (int p = 2; p < 4; p++) begin
      push0(mk(0, p, 0, 1, 0)); push0(mk(0, p, 1, 0, 1));
      push1(mk(1, p, 0, 1, 0)); push1(mk(1, p, 1, 0, 1));
      for (int q = 0; q < 2; q++) begin
        exp_q.push_back(mk(q, p, 0, 1, 0));
        exp_q.push_back(mk(q, p, 1, 0, 1));
      end
    end
    repeat (12) @(negedge clk);
    checks++; if (cap.size() !== exp_q.size()) begin errors++; $display("FAIL rr_count got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++; if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL rr_beat%0d got %h want %h", i, cap[i], exp_q[i]); end
    end
    checks++; if (cnt0 !== 32'd2 || cnt1 !== 32'd2) begin errors++; $display("FAIL rr_cnts got %0d/%0d want 2/2", cnt0, cnt1); end
  endtask

  task automatic test_single_beat;
    apply_reset;
    for (int b = 0; b < 4; b++) push1(mk(1, 4, b, 1, 1));
    @(negedge clk);
    checks++; if (valid !== 1'b0 || q1_rd !== 1'b1) begin errors++; $display("FAIL sb_latency got valid=%b rd=%b want 0/1", valid, q1_rd); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b1 || beat !== mk(1, 4, b, 1, 1)) begin
        errors++; $display("FAIL sb_beat%0d got v=%b %h want v=1 %h", b, valid, beat, mk(1, 4, b, 1, 1));
      end
    end
    @(negedge clk);
    checks++; if (cnt1 !== 32'd4 || cnt0 !== 32'd0) begin errors++; $display("FAIL sb_cnts got %0d/%0d want 0/4", cnt0, cnt1); end
  endtask

  task automatic test_backpressure;
    apply_reset;
    for (int b = 0; b < 4; b++) begin
      push0(mk(0, 5, b, b == 0, b == 3));
      exp_q.push_back(mk(0, 5, b, b == 0, b == 3));
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b1 || beat !== mk(0, 5, 1, 0, 0) || q0_rd !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%b rd=%b %h want v=1 rd=0 %h", c, valid, q0_rd, beat, mk(0, 5, 1, 0, 0));
      end
    end
    @(posedge clk);
    #1;
    ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (cap.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++; if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, cap[i], exp_q[i]); end
    end
    checks++; if (cnt0 !== 32'd1) begin errors++; $display("FAIL bp_cnt got %0d want 1", cnt0); end
  endtask

  task automatic test_frame_err;
    apply_reset;
    push0(mk(0, 6, 0, 0, 0));
    exp_q.push_back(mk(0, 7, 0, 1, 0));
    exp_q.push_back(mk(0, 7, 1, 0, 1));
    exp_q.push_back(mk(0, 8, 0, 1, 0));
    exp_q.push_back(mk(0, 8, 1, 1, 0));
    exp_q.push_back(mk(0, 8, 2, 0, 1));
    foreach (exp_q[i]) push0(exp_q[i]);
    @(negedge clk);
    checks++; if (q0_rd !== 1'b1) begin errors++; $display("FAIL fe_pop got %b want 1", q0_rd); end
    @(negedge clk);
    checks++; if (valid !== 1'b0 || errc !== 32'd1) begin errors++; $display("FAIL fe_discard got valid=%b err=%0d want 0/1", valid, errc); end
    repeat (8) @(negedge clk);
    checks++; if (cap.size() !== exp_q.size()) begin errors++; $display("FAIL fe_count got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++; if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL fe_beat%0d got %h want %h", i, cap[i], exp_q[i]); end
    end
    checks++; if (errc !== 32'd2 || cnt0 !== 32'd2) begin errors++; $display("FAIL fe_cnts got err=%0d cnt0=%0d want 2/2", errc, cnt0); end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    for (int b = 0; b < 4; b++) push0(mk(0, 9, b, b == 0, b == 3));
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b1 || beat !== mk(0, 9, 1, 0, 0)) begin errors++; $display("FAIL rm_pre got v=%b %h want v=1 %h", valid, beat, mk(0, 9, 1, 0, 0)); end
    rst_n = 1'b0;
    t0 = h0;
    t1 = h1;
    #1;
    checks++; if (valid !== 1'b0 || beat !== '0 || {cnt0, cnt1, errc} !== '0) begin
      errors++; $display("FAIL rm_async got v=%b %h cnts=%0d/%0d/%0d want all 0", valid, beat, cnt0, cnt1, errc);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap.delete();
    push1(mk(1, 10, 0, 1, 0)); push1(mk(1, 10, 1, 0, 1));
    push0(mk(0, 11, 0, 1, 0)); push0(mk(0, 11, 1, 0, 1));
    exp_q = '{mk(0, 11, 0, 1, 0), mk(0, 11, 1, 0, 1), mk(1, 10, 0, 1, 0), mk(1, 10, 1, 0, 1)};
    repeat (8) @(negedge clk);
    checks++; if (cap.size() !== exp_q.size()) begin errors++; $display("FAIL rm_count got %0d want %0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++; if (cap[i] !== exp_q[i]) begin errors++; $display("FAIL rm_beat%0d got %h want %h", i, cap[i], exp_q[i]); end
    end
    checks++; if (cnt0 !== 32'd1 || cnt1 !== 32'd1) begin errors++; $display("FAIL rm_cnts got %0d/%0d want 1/1", cnt0, cnt1); end
  endtask

  initial begin
    test_reset;
    test_single_pkt;
    test_round_robin;
    test_single_beat;
    test_backpressure;
    test_frame_err;
    test_reset_mid;
    checks++; if (dual_err !== 0) begin errors++; $display("FAIL dual_rd_total got %0d want 0", dual_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
